// File: rtl/io_pmp_check_arbiter_if.sv
// Address-check request, PMP and decision signals of the IO-PMP check arbiter.
// Denial counter signals exist only when IO_PMP_ARB_STATS_EN is defined.
interface io_pmp_check_arbiter_if #(
    parameter int unsigned PLEN = 56
`ifdef IO_PMP_ARB_STATS_EN
    , parameter int unsigned CNT_WIDTH = 16
`endif
);
    logic            ar_valid_i;
    logic            ar_ready_o;
    logic [PLEN-1:0] ar_addr_i;
    logic            aw_valid_i;
    logic            aw_ready_o;
    logic [PLEN-1:0] aw_addr_i;
    logic [PLEN-1:0] pmp_addr_o;
    logic [2:0]      pmp_access_o;
    logic            pmp_allow_i;
    logic            ar_dec_valid_o;
    logic            ar_dec_ready_i;
    logic            ar_dec_allow_o;
    logic            aw_dec_valid_o;
    logic            aw_dec_ready_i;
    logic            aw_dec_allow_o;
`ifdef IO_PMP_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] ar_deny_cnt_o;
    logic [CNT_WIDTH-1:0] aw_deny_cnt_o;
    logic                 cnt_clr_i;

    modport slave (
        input  ar_valid_i, ar_addr_i, aw_valid_i, aw_addr_i, pmp_allow_i,
               ar_dec_ready_i, aw_dec_ready_i, cnt_clr_i,
        output ar_ready_o, aw_ready_o, pmp_addr_o, pmp_access_o,
               ar_dec_valid_o, ar_dec_allow_o, aw_dec_valid_o, aw_dec_allow_o,
               ar_deny_cnt_o, aw_deny_cnt_o
    );

    modport master (
        output ar_valid_i, ar_addr_i, aw_valid_i, aw_addr_i, pmp_allow_i,
               ar_dec_ready_i, aw_dec_ready_i, cnt_clr_i,
        input  ar_ready_o, aw_ready_o, pmp_addr_o, pmp_access_o,
               ar_dec_valid_o, ar_dec_allow_o, aw_dec_valid_o, aw_dec_allow_o,
               ar_deny_cnt_o, aw_deny_cnt_o
    );
`else
    modport slave (
        input  ar_valid_i, ar_addr_i, aw_valid_i, aw_addr_i, pmp_allow_i,
               ar_dec_ready_i, aw_dec_ready_i,
        output ar_ready_o, aw_ready_o, pmp_addr_o, pmp_access_o,
               ar_dec_valid_o, ar_dec_allow_o, aw_dec_valid_o, aw_dec_allow_o
    );

    modport master (
        output ar_valid_i, ar_addr_i, aw_valid_i, aw_addr_i, pmp_allow_i,
               ar_dec_ready_i, aw_dec_ready_i,
        input  ar_ready_o, aw_ready_o, pmp_addr_o, pmp_access_o,
               ar_dec_valid_o, ar_dec_allow_o, aw_dec_valid_o, aw_dec_allow_o
    );
`endif
endinterface

// File: rtl/io_pmp_check_arbiter.sv
// Round-robin sharing of one combinational PMP check between the AR and AW address channels.
// Optional per-channel denial counters are enabled by defining IO_PMP_ARB_STATS_EN.
module io_pmp_check_arbiter #(
    parameter int unsigned PLEN = 56
`ifdef IO_PMP_ARB_STATS_EN
    , parameter int unsigned CNT_WIDTH = 16
`endif
) (
    input logic clk_i,
    input logic rst_ni,
    io_pmp_check_arbiter_if.slave arb
);
    localparam logic [2:0] ACCESS_READ  = 3'b001;
    localparam logic [2:0] ACCESS_WRITE = 3'b010;

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    state_t          state_q;
    logic            sel_q;
    logic            rr_q;
    logic            allow_q;
    logic [PLEN-1:0] addr_q;
    logic            ar_grant;
    logic            aw_grant;
    logic            dec_hs;

    // Readies are gated by reset so every output reads 0 while reset is held.
    assign ar_grant = rst_ni & (state_q == IDLE) & arb.ar_valid_i & (~arb.aw_valid_i | ~rr_q);
    assign aw_grant = rst_ni & (state_q == IDLE) & arb.aw_valid_i & (~arb.ar_valid_i | rr_q);
    assign dec_hs   = (state_q == RESP) & (sel_q ? arb.aw_dec_ready_i : arb.ar_dec_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            rr_q    <= 1'b0;
            allow_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ar_grant || aw_grant) begin
                        addr_q  <= aw_grant ? arb.aw_addr_i : arb.ar_addr_i;
                        sel_q   <= aw_grant;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    allow_q <= arb.pmp_allow_i;
                    state_q <= RESP;
                end
                RESP: begin
                    if (dec_hs) begin
                        rr_q    <= ~sel_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb.ar_ready_o     = ar_grant;
    assign arb.aw_ready_o     = aw_grant;
    assign arb.pmp_addr_o     = addr_q;
    assign arb.pmp_access_o   = sel_q ? ACCESS_WRITE : ACCESS_READ;
    assign arb.ar_dec_valid_o = (state_q == RESP) & ~sel_q;
    assign arb.aw_dec_valid_o = (state_q == RESP) & sel_q;
    assign arb.ar_dec_allow_o = (state_q == RESP) & ~sel_q & allow_q;
    assign arb.aw_dec_allow_o = (state_q == RESP) & sel_q & allow_q;

`ifdef IO_PMP_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] ar_cnt_q;
    logic [CNT_WIDTH-1:0] aw_cnt_q;

    // Clear has priority over a coincident denial; counters stick at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_cnt_q <= '0;
            aw_cnt_q <= '0;
        end else if (arb.cnt_clr_i) begin
            ar_cnt_q <= '0;
            aw_cnt_q <= '0;
        end else if (dec_hs && !allow_q) begin
            if (!sel_q && (ar_cnt_q != '1)) ar_cnt_q <= ar_cnt_q + CNT_WIDTH'(1);
            if (sel_q && (aw_cnt_q != '1))  aw_cnt_q <= aw_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign arb.ar_deny_cnt_o = ar_cnt_q;
    assign arb.aw_deny_cnt_o = aw_cnt_q;
`endif
endmodule

// File: tb/tb_io_pmp_check_arbiter.sv
// Directed self-checking bench for io_pmp_check_arbiter; stats checks use a 4-bit counter
// build so saturation is reachable quickly when IO_PMP_ARB_STATS_EN is defined.
module tb_io_pmp_check_arbiter;
    localparam int unsigned PLEN = 56;
    localparam logic [63:0] ACC_READ  = 64'd1;
    localparam logic [63:0] ACC_WRITE = 64'd2;

    logic clock;
    logic resetN;
    int   checkCount;
    int   passCount;

`ifdef IO_PMP_ARB_STATS_EN
    io_pmp_check_arbiter_if #(.PLEN(PLEN), .CNT_WIDTH(4)) bus ();
    io_pmp_check_arbiter #(.PLEN(PLEN), .CNT_WIDTH(4)) dut (
        .clk_i  (clock),
        .rst_ni (resetN),
        .arb    (bus)
    );
`else
    io_pmp_check_arbiter_if #(.PLEN(PLEN)) bus ();
    io_pmp_check_arbiter #(.PLEN(PLEN)) dut (
        .clk_i  (clock),
        .rst_ni (resetN),
        .arb    (bus)
    );
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic arValid, input logic [63:0] arAddr,
                                 input logic awValid, input logic [63:0] awAddr,
                                 input logic pmpAllow);
        bus.ar_valid_i  = arValid;
        bus.ar_addr_i   = arAddr[PLEN-1:0];
        bus.aw_valid_i  = awValid;
        bus.aw_addr_i   = awAddr[PLEN-1:0];
        bus.pmp_allow_i = pmpAllow;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        resetN     = 1'b0;
        bus.ar_dec_ready_i = 1'b0;
        bus.aw_dec_ready_i = 1'b0;
`ifdef IO_PMP_ARB_STATS_EN
        bus.cnt_clr_i = 1'b0;
`endif
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);

        // Reset state
        stepCycle();
        checkOutput("rst_ar_ready", 64'(bus.ar_ready_o), 64'd0);
        checkOutput("rst_ar_dec_valid", 64'(bus.ar_dec_valid_o), 64'd0);
        checkOutput("rst_aw_dec_valid", 64'(bus.aw_dec_valid_o), 64'd0);
        checkOutput("rst_pmp_access", 64'(bus.pmp_access_o), ACC_READ);
        checkOutput("rst_pmp_addr", 64'(bus.pmp_addr_o), 64'h0);
`ifdef IO_PMP_ARB_STATS_EN
        checkOutput("rst_ar_cnt", 64'(bus.ar_deny_cnt_o), 64'd0);
`endif
        resetN = 1'b1;
        stepCycle();

        // AR-only request, allowed
        applyStimulus(1'b1, 64'h1000, 1'b0, 64'h0, 1'b1);
        checkOutput("t1_ar_ready", 64'(bus.ar_ready_o), 64'd1);
        checkOutput("t1_aw_ready", 64'(bus.aw_ready_o), 64'd0);
        stepCycle();
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        checkOutput("t1_chk_access", 64'(bus.pmp_access_o), ACC_READ);
        checkOutput("t1_chk_addr", 64'(bus.pmp_addr_o), 64'h1000);
        checkOutput("t1_chk_ready", 64'(bus.ar_ready_o), 64'd0);
        stepCycle();
        checkOutput("t1_dec_valid", 64'(bus.ar_dec_valid_o), 64'd1);
        checkOutput("t1_dec_allow", 64'(bus.ar_dec_allow_o), 64'd1);
        checkOutput("t1_aw_dec_valid", 64'(bus.aw_dec_valid_o), 64'd0);
        bus.ar_dec_ready_i = 1'b1;
        stepCycle();
        bus.ar_dec_ready_i = 1'b0;
        checkOutput("t1_dec_done", 64'(bus.ar_dec_valid_o), 64'd0);

        // AW-only request, denied
        applyStimulus(1'b0, 64'h0, 1'b1, 64'h2000, 1'b0);
        checkOutput("t2_aw_ready", 64'(bus.aw_ready_o), 64'd1);
        stepCycle();
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        checkOutput("t2_chk_access", 64'(bus.pmp_access_o), ACC_WRITE);
        checkOutput("t2_chk_addr", 64'(bus.pmp_addr_o), 64'h2000);
        stepCycle();
        checkOutput("t2_dec_valid", 64'(bus.aw_dec_valid_o), 64'd1);
        checkOutput("t2_dec_allow", 64'(bus.aw_dec_allow_o), 64'd0);
        checkOutput("t2_ar_dec_valid", 64'(bus.ar_dec_valid_o), 64'd0);
        bus.aw_dec_ready_i = 1'b1;
        stepCycle();
        bus.aw_dec_ready_i = 1'b0;
`ifdef IO_PMP_ARB_STATS_EN
        checkOutput("t2_aw_cnt", 64'(bus.aw_deny_cnt_o), 64'd1);
        checkOutput("t2_ar_cnt", 64'(bus.ar_deny_cnt_o), 64'd0);
`endif

        // Both channels requesting continuously from reset: grants alternate
        resetN = 1'b0;
        stepCycle();
        resetN = 1'b1;
        bus.ar_dec_ready_i = 1'b1;
        bus.aw_dec_ready_i = 1'b1;
        applyStimulus(1'b1, 64'h3000, 1'b1, 64'h4000, 1'b1);
        for (int g = 0; g < 4; g++) begin
            logic expAw;
            expAw = (g % 2) == 1;
            checkOutput("t3_ar_grant", 64'(bus.ar_ready_o), 64'(!expAw));
            checkOutput("t3_aw_grant", 64'(bus.aw_ready_o), 64'(expAw));
            stepCycle();
            checkOutput("t3_chk_addr", 64'(bus.pmp_addr_o), expAw ? 64'h4000 : 64'h3000);
            stepCycle();
            checkOutput("t3_ar_dec", 64'(bus.ar_dec_valid_o), 64'(!expAw));
            checkOutput("t3_aw_dec", 64'(bus.aw_dec_valid_o), 64'(expAw));
            stepCycle();
        end

        // Decision back-pressure on AR while AW waits
        bus.ar_dec_ready_i = 1'b0;
        bus.aw_dec_ready_i = 1'b0;
        applyStimulus(1'b1, 64'h6000, 1'b1, 64'h7000, 1'b0);
        checkOutput("t4_ar_grant", 64'(bus.ar_ready_o), 64'd1);
        stepCycle();
        applyStimulus(1'b0, 64'h0, 1'b1, 64'h7000, 1'b0);
        stepCycle();
        checkOutput("t4_dec_valid", 64'(bus.ar_dec_valid_o), 64'd1);
        checkOutput("t4_dec_allow", 64'(bus.ar_dec_allow_o), 64'd0);
        applyStimulus(1'b0, 64'h0, 1'b1, 64'h7000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            checkOutput("t4_hold_aw_ready", 64'(bus.aw_ready_o), 64'd0);
            checkOutput("t4_hold_valid", 64'(bus.ar_dec_valid_o), 64'd1);
            checkOutput("t4_hold_allow", 64'(bus.ar_dec_allow_o), 64'd0);
        end
        bus.ar_dec_ready_i = 1'b1;
        stepCycle();
        bus.ar_dec_ready_i = 1'b0;
        checkOutput("t4_aw_grant", 64'(bus.aw_ready_o), 64'd1);
        checkOutput("t4_ar_quiet", 64'(bus.ar_ready_o), 64'd0);
        stepCycle();
        checkOutput("t4_aw_check", 64'(bus.pmp_access_o), ACC_WRITE);

        // Asynchronous reset during CHECK
        resetN = 1'b0;
        #1;
        checkOutput("t5_rst_access", 64'(bus.pmp_access_o), ACC_READ);
        checkOutput("t5_rst_addr", 64'(bus.pmp_addr_o), 64'h0);
        checkOutput("t5_rst_aw_ready", 64'(bus.aw_ready_o), 64'd0);
        checkOutput("t5_rst_aw_dec", 64'(bus.aw_dec_valid_o), 64'd0);
        applyStimulus(1'b1, 64'h8000, 1'b1, 64'h9000, 1'b1);
        resetN = 1'b1;
        #1;
        checkOutput("t5_ar_first", 64'(bus.ar_ready_o), 64'd1);
        checkOutput("t5_aw_wait", 64'(bus.aw_ready_o), 64'd0);
        stepCycle();
        stepCycle();
        checkOutput("t5_ar_dec", 64'(bus.ar_dec_valid_o), 64'd1);
        checkOutput("t5_aw_dec", 64'(bus.aw_dec_valid_o), 64'd0);
        bus.ar_dec_ready_i = 1'b1;
        stepCycle();
        bus.ar_dec_ready_i = 1'b0;
        checkOutput("t5_aw_next", 64'(bus.aw_ready_o), 64'd1);
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);

        // Request withdrawn before the edge leaves the arbiter idle
        applyStimulus(1'b1, 64'h5000, 1'b0, 64'h0, 1'b1);
        applyStimulus(1'b0, 64'h5000, 1'b0, 64'h0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 64'h0, 1'b1, 64'hA000, 1'b1);
        checkOutput("b_drop_idle", 64'(bus.aw_ready_o), 64'd1);
        checkOutput("b_drop_addr", 64'(bus.pmp_addr_o), 64'h8000);
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);

`ifdef IO_PMP_ARB_STATS_EN
        // Saturating AR denial counter and clear priority
        checkOutput("s_cnt_start", 64'(bus.ar_deny_cnt_o), 64'd0);
        bus.ar_dec_ready_i = 1'b1;
        applyStimulus(1'b1, 64'hB000, 1'b0, 64'h0, 1'b0);
        for (int d = 0; d < 17; d++) begin
            stepCycle();
            stepCycle();
            stepCycle();
        end
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        checkOutput("s_ar_sat", 64'(bus.ar_deny_cnt_o), 64'hF);
        checkOutput("s_aw_idle", 64'(bus.aw_deny_cnt_o), 64'd0);
        applyStimulus(1'b1, 64'hC000, 1'b0, 64'h0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        stepCycle();
        checkOutput("s_clr_resp", 64'(bus.ar_dec_valid_o), 64'd1);
        bus.cnt_clr_i = 1'b1;
        stepCycle();
        bus.cnt_clr_i = 1'b0;
        bus.ar_dec_ready_i = 1'b0;
        checkOutput("s_clr_wins", 64'(bus.ar_deny_cnt_o), 64'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
